issue_stage: RTL and testbench
==============================

Name: issue_stage

Overview:
- Producer end of the decoded-instruction stream that the execute units consume.
- Takes decoded instructions from the decoder and reads rs1/rs2 values from the register file.
- Tracks pending destination registers in a scoreboard and holds instructions with unresolved source hazards.
- Presents one operand-complete instruction per cycle on a decoupled output.
- Register-file writes from the execute unit's result both clear scoreboard bits and forward into operands.

Parameters:
- REG_CNT, 32, number of architectural GPRs; index width is clog2(REG_CNT); x0 is hardwired zero.
- XLEN, 32, operand and result width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- dec  decoupled.in  -  decoded instruction from the decoder; data.rs1_val/rs2_val are ignored on input.
- issue  decoupled.out  -  decoded instruction with rs1_val/rs2_val filled, to the execute unit.
- rf_rs1_idx  output  5  register-file read index 1, driven combinationally from dec.data.rs1.
- rf_rs2_idx  output  5  register-file read index 2, driven combinationally from dec.data.rs2.
- rf_rs1_val  input  XLEN  combinational read data for index 1.
- rf_rs2_val  input  XLEN  combinational read data for index 2.
- wb_valid  input  1  the wb bundle is valid this cycle.
- wb  input  exec_result  writeback from execute: rd_idx, rd_val, br_valid, br_target.
- flush  input  1  pipeline flush (branch redirect).
- stall_cnt  output  32  hazard-stall cycle count (see Optional Feature).

Behaviour:
- Reset (rst=0, async):
  - slot_valid=0, so issue.valid=0.
  - scoreboard=0; slot data=0; stall_cnt=0.
  - dec.ready=0 while reset is asserted.
- Source usage, derived from dec.data.op:
  - rs1 is used unless op is LUI, AUIPC or JAL.
  - rs2 is used only for OP, BRANCH and STORE.
  - An index of 0 is never a hazard and always yields operand 0.
- Hazard: a used source rs (nonzero) has scoreboard[rs]=1 AND NOT (wb_valid && wb.rd_idx==rs).
- Operand select, per used source, in priority order:
  - rs==0 gives 0.
  - wb_valid && wb.rd_idx==rs gives wb.rd_val (same-cycle bypass).
  - Otherwise the rf value.
- Slot drain: drain = slot_valid && issue.ready.
- Input readiness: dec.ready = !flush && !hazard && (!slot_valid || drain). It is combinational and may depend on dec.valid/data.
- Accept = dec.valid && dec.ready. On accept, next cycle:
  - slot_valid=1.
  - Slot holds dec.data with the selected operands.
  - If rd!=0, scoreboard[rd] is set.
- Drain without accept: slot_valid becomes 0 next cycle.
- Latency: exactly 1 cycle from accept to issue.valid. Back-to-back issue of independent instructions sustains 1 per cycle.
- Writeback: when wb_valid and wb.rd_idx!=0, scoreboard[wb.rd_idx] is cleared. If an accept sets the same index in the same cycle, set wins, because the new instruction is younger.
- issue.data and issue.valid stay stable while issue.valid && !issue.ready.
- Flush, synchronous:
  - Next cycle slot_valid=0 and scoreboard=0.
  - Accept is blocked that cycle.
  - wb in the same cycle still bypasses nothing and is otherwise discarded.
  - Drain in the same cycle still counts as issued to execute; squashing it downstream is execute's job.
- wb.br_valid/br_target are not used by this block; flush is the only redirect path.

Optional Feature:
- Macro: ISSUE_STALL_CNT_EN.
- Enabled: stall_cnt increments by 1, wrapping modulo 2^32, on every cycle with dec.valid && !flush && hazard. Cycles stalled only because the slot is full are not counted. Reset value is 0; flush does not clear it.
- Disabled: stall_cnt is tied to 0 and no counter flops are instantiated.

Test Plan:
- Reset, then `ADDI x1,x0,5` with issue.ready=1:
  - Accepted at cycle 0; issue.valid=1 at cycle 1 with rs1_val=0.
  - scoreboard[1]=1; wb(rd=1, val=5) clears it.
- Hazard then bypass:
  - scoreboard[1] set and dec=`ADD x2,x1,x1` held valid, so dec.ready=0 and stall_cnt increments each cycle (macro on).
  - wb_valid with rd_idx=1, rd_val=0x1234 gives same-cycle accept; issued rs1_val=rs2_val=0x1234.
- Backpressure:
  - issue.ready=0 with slot full; a second independent instruction sees dec.ready=0.
  - issue.data stays unchanged for 3 cycles.
  - Raising issue.ready drains the slot and accepts the second instruction in the same cycle.
- Same-index set/clear: accept `ADDI x3,...` in the same cycle as wb(rd=3) gives scoreboard[3]=1 afterwards.
- Flush:
  - Slot valid and scoreboard={x1,x4} pending; assert flush with dec.valid=1.
  - dec.ready=0 that cycle; next cycle issue.valid=0, scoreboard=0, and a dependent `ADD x5,x4,x1` is accepted with no stall.
- Async reset mid-stall: drop rst between clock edges, so issue.valid falls immediately, scoreboard clears, and stall_cnt=0.

Source files
------------

// File: rtl/issue_stage_if.sv
// ---------------------------------------------------------------------------
// issue_pkg / issue_stage_if
//
// Purpose: shared types for the issue stage and the decoupled valid/ready
// bundle that carries decoded instructions into and out of it.
//
// issue_pkg:
//   ISSUE_REG_CNT / ISSUE_XLEN / IDX_W  register count, data width, index width
//   OPC_*                               RV32 major opcodes the stage decodes
//   decoded_instr_t                     op, rd, rs1, rs2, imm, rs1_val, rs2_val
//   exec_result_t                       rd_idx, rd_val, br_valid, br_target
//
// issue_stage_if ports (modport view):
//   master : drives valid, data; samples ready
//   slave  : samples valid, data; drives ready
// ---------------------------------------------------------------------------
package issue_pkg;
  localparam int ISSUE_REG_CNT = 32;
  localparam int ISSUE_XLEN    = 32;
  localparam int IDX_W         = $clog2(ISSUE_REG_CNT);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [6:0]            op;
    logic [IDX_W-1:0]      rd;
    logic [IDX_W-1:0]      rs1;
    logic [IDX_W-1:0]      rs2;
    logic [ISSUE_XLEN-1:0] imm;
    logic [ISSUE_XLEN-1:0] rs1_val;
    logic [ISSUE_XLEN-1:0] rs2_val;
  } decoded_instr_t;

  typedef struct packed {
    logic [IDX_W-1:0]      rd_idx;
    logic [ISSUE_XLEN-1:0] rd_val;
    logic                  br_valid;
    logic [ISSUE_XLEN-1:0] br_target;
  } exec_result_t;
endpackage

interface issue_stage_if;
  logic                     valid;
  logic                     ready;
  issue_pkg::decoded_instr_t data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/issue_stage.sv
// ---------------------------------------------------------------------------
// issue_stage
//
// Purpose: accepts decoded instructions, reads their sources from the
// register file (with same-cycle writeback bypass), holds them back while a
// source is still pending in the scoreboard, and presents one
// operand-complete instruction per cycle to the execute unit.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   dec         decoupled input from the decoder (rs*_val ignored)
//   issue       decoupled output to execute with rs1_val/rs2_val filled
//   rf_rs1_idx  register-file read index 1 (combinational from dec.data.rs1)
//   rf_rs2_idx  register-file read index 2 (combinational from dec.data.rs2)
//   rf_rs1_val  register-file read data 1
//   rf_rs2_val  register-file read data 2
//   wb_valid    writeback bundle valid
//   wb          writeback from execute (branch fields unused here)
//   flush       synchronous pipeline flush
//   stall_cnt   hazard-stall cycle counter
//
// Optional feature: define ISSUE_STALL_CNT_EN to build the hazard-stall
// counter; otherwise stall_cnt is constant zero and no counter flops exist.
// ---------------------------------------------------------------------------
module issue_stage
  import issue_pkg::*;
#(
  parameter int REG_CNT = ISSUE_REG_CNT,
  parameter int XLEN    = ISSUE_XLEN
) (
  input  logic                 clk,
  input  logic                 rst,
  issue_stage_if.slave         dec,
  issue_stage_if.master        issue,
  output logic [IDX_W-1:0]     rf_rs1_idx,
  output logic [IDX_W-1:0]     rf_rs2_idx,
  input  logic [XLEN-1:0]      rf_rs1_val,
  input  logic [XLEN-1:0]      rf_rs2_val,
  input  logic                 wb_valid,
  input  exec_result_t         wb,
  input  logic                 flush,
  output logic [31:0]          stall_cnt
);

  logic                 slot_valid_q, slot_valid_d;
  decoded_instr_t       slot_data_q, slot_data_d;
  logic [REG_CNT-1:0]   sb_q, sb_d;

  logic                 use_rs1, use_rs2;
  logic                 wb_hit1, wb_hit2;
  logic                 hazard;
  logic                 drain, accept;
  logic [XLEN-1:0]      op1, op2;

  // Branch information is consumed elsewhere; flush is the only redirect.
  logic                 unused_wb_br;
  assign unused_wb_br = wb.br_valid ^ (^wb.br_target);

  assign rf_rs1_idx = dec.data.rs1;
  assign rf_rs2_idx = dec.data.rs2;

  // Source decode, hazard detection and operand selection. A writeback
  // hitting a pending source both resolves the hazard and supplies the
  // value in the same cycle. Unused sources carry zero.
  always_comb begin
    use_rs1 = !(dec.data.op == OPC_LUI || dec.data.op == OPC_AUIPC ||
                dec.data.op == OPC_JAL);
    use_rs2 = (dec.data.op == OPC_OP || dec.data.op == OPC_BRANCH ||
               dec.data.op == OPC_STORE);

    wb_hit1 = wb_valid && (wb.rd_idx == dec.data.rs1);
    wb_hit2 = wb_valid && (wb.rd_idx == dec.data.rs2);

    hazard = (use_rs1 && (dec.data.rs1 != '0) && sb_q[dec.data.rs1] && !wb_hit1) ||
             (use_rs2 && (dec.data.rs2 != '0) && sb_q[dec.data.rs2] && !wb_hit2);

    op1 = '0;
    if (use_rs1 && dec.data.rs1 != '0) begin
      op1 = wb_hit1 ? wb.rd_val : rf_rs1_val;
    end
    op2 = '0;
    if (use_rs2 && dec.data.rs2 != '0) begin
      op2 = wb_hit2 ? wb.rd_val : rf_rs2_val;
    end
  end

  // Handshakes. dec.ready is forced low during reset so the decoder never
  // sees a transfer that the held-in-reset flops would lose.
  always_comb begin
    drain     = slot_valid_q && issue.ready;
    dec.ready = rst && !flush && !hazard && (!slot_valid_q || drain);
    accept    = dec.valid && dec.ready;
  end

  assign issue.valid = slot_valid_q;
  assign issue.data  = slot_data_q;

  // Next-state for slot and scoreboard. Writeback clears before the accept
  // sets, so a younger instruction targeting the same register keeps its
  // pending bit. Flush wipes all pending state last.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_data_d  = slot_data_q;
    sb_d         = sb_q;

    if (accept) begin
      slot_valid_d         = 1'b1;
      slot_data_d          = dec.data;
      slot_data_d.rs1_val  = op1;
      slot_data_d.rs2_val  = op2;
    end else if (drain) begin
      slot_valid_d = 1'b0;
    end

    if (wb_valid && wb.rd_idx != '0) begin
      sb_d[wb.rd_idx] = 1'b0;
    end
    if (accept && dec.data.rd != '0) begin
      sb_d[dec.data.rd] = 1'b1;
    end

    if (flush) begin
      slot_valid_d = 1'b0;
      sb_d         = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid_q <= 1'b0;
      slot_data_q  <= '0;
      sb_q         <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      sb_q         <= sb_d;
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  // Counts only cycles lost to source hazards, not to a full slot.
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (dec.valid && !flush && hazard) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_issue_stage
//
// Purpose: directed and randomized stimulus for issue_stage, checked every
// cycle against a reference model built from pending-register sets and a
// single held instruction. Inputs change on the falling edge and outputs
// are sampled 1 ns later; model state commits on the rising edge.
// ---------------------------------------------------------------------------
module tb_issue_stage;
  import issue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  issue_stage_if dec_if ();
  issue_stage_if issue_if ();

  logic [IDX_W-1:0]      rf_rs1_idx, rf_rs2_idx;
  logic [ISSUE_XLEN-1:0] rf_rs1_val, rf_rs2_val;
  logic                  wb_valid;
  exec_result_t          wb;
  logic                  flush;
  logic [31:0]           stall_cnt;

  issue_stage dut (
    .clk        (clk),
    .rst        (rst),
    .dec        (dec_if),
    .issue      (issue_if),
    .rf_rs1_idx (rf_rs1_idx),
    .rf_rs2_idx (rf_rs2_idx),
    .rf_rs1_val (rf_rs1_val),
    .rf_rs2_val (rf_rs2_val),
    .wb_valid   (wb_valid),
    .wb         (wb),
    .flush      (flush),
    .stall_cnt  (stall_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit             pend [32];
  bit             m_valid;
  decoded_instr_t m_slot;
  logic [31:0]    m_stall;

  logic [6:0] op_pool [9] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                              OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP};

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkData(input string tag, input decoded_instr_t obs, input decoded_instr_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic decoded_instr_t mk(input logic [6:0] op, input int rd, input int rs1,
                                        input int rs2, input logic [31:0] imm);
    decoded_instr_t d;
    d         = '0;
    d.op      = op;
    d.rd      = IDX_W'(rd);
    d.rs1     = IDX_W'(rs1);
    d.rs2     = IDX_W'(rs2);
    d.imm     = imm;
    return d;
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op == OPC_OP || op == OPC_BRANCH || op == OPC_STORE;
  endfunction

  // A source is blocked when it is pending and this cycle's writeback is
  // not delivering it.
  function automatic bit src_blocked(input bit used, input logic [IDX_W-1:0] idx);
    if (!used || idx == 0) return 1'b0;
    return pend[idx] && !(wb_valid && wb.rd_idx == idx);
  endfunction

  function automatic logic [31:0] src_value(input bit used, input logic [IDX_W-1:0] idx,
                                            input logic [31:0] rf_val);
    if (!used || idx == 0) return 32'd0;
    if (wb_valid && wb.rd_idx == idx) return wb.rd_val;
    return rf_val;
  endfunction

  task automatic resetModel();
    foreach (pend[i]) pend[i] = 1'b0;
    m_valid = 1'b0;
    m_slot  = '0;
    m_stall = '0;
  endtask

  // Drives one cycle of inputs on the falling edge and lets them settle.
  task automatic applyStimulus(input bit dv, input decoded_instr_t ins, input bit ir,
                               input bit wv, input int wrd, input logic [31:0] wval,
                               input bit fl);
    decoded_instr_t d;
    d             = ins;
    d.rs1_val     = $urandom;
    d.rs2_val     = $urandom;
    dec_if.valid  = dv;
    dec_if.data   = d;
    issue_if.ready = ir;
    wb_valid      = wv;
    wb.rd_idx     = IDX_W'(wrd);
    wb.rd_val     = wval;
    wb.br_valid   = 1'($urandom);
    wb.br_target  = $urandom;
    flush         = fl;
    rf_rs1_val    = $urandom;
    rf_rs2_val    = $urandom;
    #1;
  endtask

  // Compares every output with the model, then advances the model across
  // the next rising edge and returns on the following falling edge.
  task automatic checkOutput(input string tag);
    bit             hz, exp_ready, acc;
    bit             n_valid;
    decoded_instr_t n_slot;
    bit             n_pend [32];
    logic [31:0]    n_stall;
    logic [6:0]     op;

    op = dec_if.data.op;
    hz = src_blocked(reads_rs1(op), dec_if.data.rs1) || src_blocked(reads_rs2(op), dec_if.data.rs2);
    exp_ready = rst && !flush && !hz && (!m_valid || issue_if.ready);

    checkEq({tag, ".dec_ready"}, 32'(dec_if.ready), 32'(exp_ready));
    checkEq({tag, ".issue_valid"}, 32'(issue_if.valid), 32'(m_valid));
    if (m_valid) checkData({tag, ".issue_data"}, issue_if.data, m_slot);
`ifdef ISSUE_STALL_CNT_EN
    checkEq({tag, ".stall_cnt"}, stall_cnt, m_stall);
`else
    checkEq({tag, ".stall_cnt"}, stall_cnt, 32'd0);
`endif
    checkEq({tag, ".rf_idx"}, 32'({rf_rs1_idx, rf_rs2_idx}),
            32'({dec_if.data.rs1, dec_if.data.rs2}));

    acc     = dec_if.valid && exp_ready;
    n_valid = m_valid;
    n_slot  = m_slot;
    n_pend  = pend;
    n_stall = m_stall;
    if (acc) begin
      n_valid         = 1'b1;
      n_slot          = dec_if.data;
      n_slot.rs1_val  = src_value(reads_rs1(op), dec_if.data.rs1, rf_rs1_val);
      n_slot.rs2_val  = src_value(reads_rs2(op), dec_if.data.rs2, rf_rs2_val);
    end else if (m_valid && issue_if.ready) begin
      n_valid = 1'b0;
    end
    if (wb_valid && wb.rd_idx != 0) n_pend[wb.rd_idx] = 1'b0;
    if (acc && dec_if.data.rd != 0) n_pend[dec_if.data.rd] = 1'b1;
    if (flush) begin
      n_valid = 1'b0;
      foreach (n_pend[i]) n_pend[i] = 1'b0;
    end
    if (dec_if.valid && !flush && hz) n_stall = m_stall + 32'd1;

    @(posedge clk);
    if (rst) begin
      m_valid = n_valid;
      m_slot  = n_slot;
      pend    = n_pend;
      m_stall = n_stall;
    end
    @(negedge clk);
  endtask

  initial begin
    decoded_instr_t nop_i, ins;
    resetModel();
    nop_i = mk(OPC_OP_IMM, 0, 0, 0, 0);

    // Reset held: nothing valid, nothing accepted.
    @(negedge clk);
    applyStimulus(1, mk(OPC_OP_IMM, 1, 0, 0, 5), 1, 0, 0, 0, 0);
    checkEq("reset.dec_ready", 32'(dec_if.ready), 0);
    checkOutput("reset");
    rst = 1'b1;

    // ADDI x1,x0,5 issues one cycle after accept with rs1_val=0.
    applyStimulus(1, mk(OPC_OP_IMM, 1, 0, 0, 5), 1, 0, 0, 0, 0);
    checkEq("addi.accept", 32'(dec_if.ready), 1);
    checkOutput("addi");
    applyStimulus(0, nop_i, 1, 0, 0, 0, 0);
    checkEq("addi.valid", 32'(issue_if.valid), 1);
    checkEq("addi.rs1_val", issue_if.data.rs1_val, 0);
    checkOutput("addi_out");

    // ADD x2,x1,x1 waits for x1, then takes the bypassed value.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, mk(OPC_OP, 2, 1, 1, 0), 1, 0, 0, 0, 0);
      checkEq("hazard.stall", 32'(dec_if.ready), 0);
      checkOutput("hazard");
    end
    applyStimulus(1, mk(OPC_OP, 2, 1, 1, 0), 1, 1, 1, 32'h1234, 0);
    checkEq("bypass.accept", 32'(dec_if.ready), 1);
    checkOutput("bypass");
    applyStimulus(0, nop_i, 1, 1, 2, 32'h55, 0);
    checkEq("bypass.rs1_val", issue_if.data.rs1_val, 32'h1234);
    checkEq("bypass.rs2_val", issue_if.data.rs2_val, 32'h1234);
    checkOutput("bypass_out");

    // Backpressure: slot held for 3 cycles, then drain and accept together.
    applyStimulus(1, mk(OPC_OP_IMM, 6, 0, 0, 1), 0, 0, 0, 0, 0);
    checkOutput("bp_fill");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, mk(OPC_OP_IMM, 7, 0, 0, 2), 0, 0, 0, 0, 0);
      checkEq("bp.blocked", 32'(dec_if.ready), 0);
      checkEq("bp.hold_rd", 32'(issue_if.data.rd), 6);
      checkOutput("bp_hold");
    end
    applyStimulus(1, mk(OPC_OP_IMM, 7, 0, 0, 2), 1, 0, 0, 0, 0);
    checkEq("bp.drain_accept", 32'(dec_if.ready), 1);
    checkOutput("bp_drain");
    applyStimulus(0, nop_i, 1, 0, 0, 0, 0);
    checkEq("bp.next_rd", 32'(issue_if.data.rd), 7);
    checkOutput("bp_out");

    // Same-index set and clear: the new producer keeps x3 pending.
    applyStimulus(1, mk(OPC_OP_IMM, 3, 0, 0, 9), 1, 0, 0, 0, 0);
    checkOutput("same_a");
    applyStimulus(1, mk(OPC_OP_IMM, 3, 0, 0, 8), 1, 1, 3, 32'h9, 0);
    checkOutput("same_b");
    applyStimulus(1, mk(OPC_OP, 8, 3, 0, 0), 1, 0, 0, 0, 0);
    checkEq("same.still_pending", 32'(dec_if.ready), 0);
    checkOutput("same_c");
    applyStimulus(1, mk(OPC_OP, 8, 3, 0, 0), 1, 1, 3, 32'h8, 0);
    checkOutput("same_d");

    // Flush with x1 and x4 pending and the slot occupied.
    applyStimulus(1, mk(OPC_OP_IMM, 1, 0, 0, 1), 1, 0, 0, 0, 0);
    checkOutput("fl_a");
    applyStimulus(1, mk(OPC_OP_IMM, 4, 0, 0, 4), 1, 0, 0, 0, 0);
    checkOutput("fl_b");
    applyStimulus(1, mk(OPC_OP, 5, 4, 1, 0), 1, 1, 1, 32'h77, 1);
    checkEq("flush.blocked", 32'(dec_if.ready), 0);
    checkOutput("fl_c");
    applyStimulus(1, mk(OPC_OP, 5, 4, 1, 0), 1, 0, 0, 0, 0);
    checkEq("flush.slot_empty", 32'(issue_if.valid), 0);
    checkEq("flush.no_stall", 32'(dec_if.ready), 1);
    checkOutput("fl_d");

    // Randomized traffic over a small register window to create hazards.
    for (int n = 0; n < 400; n++) begin
      ins = mk(op_pool[$urandom_range(0, 8)], $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom);
      applyStimulus($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
                    $urandom_range(0, 19) == 0);
      checkOutput("rand");
    end

    // Asynchronous reset in the middle of a hazard stall.
    applyStimulus(0, nop_i, 1, 0, 0, 0, 1);
    checkOutput("ar_flush");
    applyStimulus(1, mk(OPC_OP_IMM, 9, 0, 0, 3), 1, 0, 0, 0, 0);
    checkOutput("ar_a");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, mk(OPC_OP, 10, 9, 9, 0), 0, 0, 0, 0, 0);
      checkOutput("ar_stall");
    end
    applyStimulus(1, mk(OPC_OP, 10, 9, 9, 0), 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    checkEq("areset.issue_valid", 32'(issue_if.valid), 0);
    checkEq("areset.stall_cnt", stall_cnt, 0);
    checkEq("areset.dec_ready", 32'(dec_if.ready), 0);
    resetModel();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1, mk(OPC_OP, 10, 9, 9, 0), 1, 0, 0, 0, 0);
    checkEq("areset.sb_clear", 32'(dec_if.ready), 1);
    checkOutput("ar_after");
    applyStimulus(0, nop_i, 1, 0, 0, 0, 0);
    checkOutput("ar_out");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
